// File: rtl/matmul_pkg.sv
// Shared parameters and state encoding for the 8x8 signed matrix-multiply sequencer.
package matmul_pkg;

    localparam int unsigned N  = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 6;
    localparam int unsigned CW = 19;

    // Counter widths: i/j index a row/column, kk indexes a pair of k-terms
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned KW = $clog2(N / 2);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/mac_pair.sv
// Pair multiply-accumulate: two signed DWxDW products summed into a CW accumulator.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en_i            accumulate this cycle
//   clr_i           start a new sum (ignore the old accumulator value)
//   a1_i,b1_i       first operand pair, signed
//   a2_i,b2_i       second operand pair, signed
//   acc_o           accumulator value, signed
module mac_pair
    import matmul_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic signed [DW-1:0] a1_i,
    input  logic signed [DW-1:0] a2_i,
    input  logic signed [DW-1:0] b1_i,
    input  logic signed [DW-1:0] b2_i,
    output logic signed [CW-1:0] acc_o
);

    logic signed [2*DW-1:0] p1;
    logic signed [2*DW-1:0] p2;
    logic signed [2*DW:0]   sum;
    logic signed [CW-1:0]   acc_q;
    logic signed [CW-1:0]   acc_d;

    // Products and their 17-bit sum, extended explicitly to avoid unsigned promotion
    always_comb begin
        p1    = a1_i * b1_i;
        p2    = a2_i * b2_i;
        sum   = $signed({p1[2*DW-1], p1}) + $signed({p2[2*DW-1], p2});
        acc_d = acc_q;
        if (en_i) begin
            acc_d = (clr_i ? CW'(0) : acc_q) + $signed({{(CW-2*DW-1){sum[2*DW]}}, sum});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for C = A x B (NxN signed): walks i/j/kk, drives A/B read addresses,
// accumulates two k-terms per cycle and writes each C element once.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   start                      pulse, sampled only in IDLE
//   busy, done                 in-progress flag, one-cycle completion pulse
//   a_addr1/2, b_addr1/2       A/B read addresses (valid during FETCH)
//   a_rd1/2, b_rd1/2           A/B read data, one cycle after the address
//   c_addr, c_data, c_we       C write port
module matmul_seq_ctrl
    import matmul_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [AW-1:0]        a_addr1,
    output logic [AW-1:0]        a_addr2,
    output logic [AW-1:0]        b_addr1,
    output logic [AW-1:0]        b_addr2,
    input  logic signed [DW-1:0] a_rd1,
    input  logic signed [DW-1:0] a_rd2,
    input  logic signed [DW-1:0] b_rd1,
    input  logic signed [DW-1:0] b_rd2,
    output logic [AW-1:0]        c_addr,
    output logic signed [CW-1:0] c_data,
    output logic                 c_we
);

    state_e        state_q, state_d;
    logic [IW-1:0] i_q, i_d;
    logic [IW-1:0] j_q, j_d;
    logic [KW-1:0] kk_q, kk_d;
    logic          valid_q, first_q;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          c_we_q, c_we_d;
    logic [AW-1:0] c_addr_q, c_addr_d;
    logic [AW-1:0] a1_q, a1_d, a2_q, a2_d, b1_q, b1_d, b2_q, b2_d;

    // Next state, counters and the registered outputs for the coming cycle
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        kk_d     = kk_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        c_we_d   = 1'b0;
        c_addr_d = '0;
        a1_d     = '0;
        a2_d     = '0;
        b1_d     = '0;
        b2_d     = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    i_d     = '0;
                    j_d     = '0;
                    kk_d    = '0;
                end
            end
            FETCH: begin
                if (kk_q == KW'(N / 2 - 1)) begin
                    state_d = DRAIN;
                    kk_d    = '0;
                end else begin
                    kk_d = kk_q + KW'(1);
                end
            end
            DRAIN: state_d = WRITE;
            WRITE: begin
                if (i_q == IW'(N - 1) && j_q == IW'(N - 1)) begin
                    state_d = DONE;
                    i_d     = '0;
                    j_d     = '0;
                end else begin
                    state_d = FETCH;
                    j_d     = j_q + IW'(1);
                    if (j_q == IW'(N - 1)) begin
                        i_d = i_q + IW'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == FETCH) || (state_d == DRAIN) || (state_d == WRITE);
        done_d = (state_d == DONE);

        // Addresses for the upcoming FETCH cycle come from the next counter values
        if (state_d == FETCH) begin
            a1_d = AW'(AW'(i_d) * AW'(N) + AW'(kk_d) * AW'(2));
            a2_d = AW'(a1_d + AW'(1));
            b1_d = AW'(AW'(kk_d) * AW'(2 * N) + AW'(j_d));
            b2_d = AW'(b1_d + AW'(N));
        end

        if (state_d == WRITE) begin
            c_we_d   = 1'b1;
            c_addr_d = AW'(AW'(i_d) * AW'(N) + AW'(j_d));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            i_q      <= '0;
            j_q      <= '0;
            kk_q     <= '0;
            valid_q  <= 1'b0;
            first_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            c_we_q   <= 1'b0;
            c_addr_q <= '0;
            a1_q     <= '0;
            a2_q     <= '0;
            b1_q     <= '0;
            b2_q     <= '0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            kk_q     <= kk_d;
            // RAM data returns one cycle after each FETCH cycle
            valid_q  <= (state_q == FETCH);
            first_q  <= (state_q == FETCH) && (kk_q == '0);
            busy_q   <= busy_d;
            done_q   <= done_d;
            c_we_q   <= c_we_d;
            c_addr_q <= c_addr_d;
            a1_q     <= a1_d;
            a2_q     <= a2_d;
            b1_q     <= b1_d;
            b2_q     <= b2_d;
        end
    end

    mac_pair u_mac (
        .clk   (clk),
        .rst   (rst),
        .en_i  (valid_q),
        .clr_i (first_q),
        .a1_i  (a_rd1),
        .a2_i  (a_rd2),
        .b1_i  (b_rd1),
        .b2_i  (b_rd2),
        .acc_o (c_data)
    );

    assign busy    = busy_q;
    assign done    = done_q;
    assign c_we    = c_we_q;
    assign c_addr  = c_addr_q;
    assign a_addr1 = a1_q;
    assign a_addr2 = a2_q;
    assign b_addr1 = b1_q;
    assign b_addr2 = b2_q;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Self-checking bench for matmul_seq_ctrl: behavioural RAMs, a plain-arithmetic
// matrix product as reference and a cycle-by-cycle timing expectation.
module tb_matmul_seq_ctrl;

    logic               clk;
    logic               rst;
    logic               start;
    logic               busy;
    logic               done;
    logic [5:0]         a_addr1, a_addr2, b_addr1, b_addr2;
    logic signed [7:0]  a_rd1, a_rd2, b_rd1, b_rd2;
    logic [5:0]         c_addr;
    logic signed [18:0] c_data;
    logic               c_we;

    logic signed [7:0]  a_mem [64];
    logic signed [7:0]  b_mem [64];
    logic signed [18:0] c_mem [64];

    int checks = 0;
    int errors = 0;

    matmul_seq_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .a_addr1 (a_addr1),
        .a_addr2 (a_addr2),
        .b_addr1 (b_addr1),
        .b_addr2 (b_addr2),
        .a_rd1   (a_rd1),
        .a_rd2   (a_rd2),
        .b_rd1   (b_rd1),
        .b_rd2   (b_rd2),
        .c_addr  (c_addr),
        .c_data  (c_data),
        .c_we    (c_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A/B RAM read ports, one-cycle latency
    always @(posedge clk) begin
        a_rd1 <= a_mem[a_addr1];
        a_rd2 <= a_mem[a_addr2];
        b_rd1 <= b_mem[b_addr1];
        b_rd2 <= b_mem[b_addr2];
    end

    task automatic check_eq(input string tag, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic longint ref_c(input int r, input int c);
        longint s = 0;
        for (int k = 0; k < 8; k++) s += longint'(a_mem[r*8+k]) * longint'(b_mem[k*8+c]);
        return s;
    endfunction

    // One multiply: start in cycle 0; rep1/rep2 re-pulse start; rst_cyc>0 asserts rst then.
    task automatic run_mult(input int rep1, input int rep2, input int rst_cyc, input bit chk_c);
        int wr_cnt = 0;
        int done_cnt = 0;
        int last_k;
        int n, ph, ii, jj;
        last_k = (rst_cyc > 0) ? rst_cyc + 8 : 390;
        if (chk_c) for (int x = 0; x < 64; x++) c_mem[x] = 19'sh15555;
        @(posedge clk);
        #1 start = 1'b1;
        for (int k = 1; k <= last_k; k++) begin
            @(posedge clk);
            #1;
            start = (k == rep1 || k == rep2);
            rst   = (rst_cyc > 0 && k == rst_cyc);
            @(negedge clk);
            if (c_we) begin
                c_mem[c_addr] = c_data;
                wr_cnt++;
            end
            if (done) done_cnt++;
            if (rst_cyc > 0 && k > rst_cyc) begin
                check_eq("busy_after_rst", longint'(busy), 0);
                check_eq("we_after_rst", longint'(c_we), 0);
                check_eq("done_after_rst", longint'(done), 0);
            end else begin
                check_eq("busy", longint'(busy), (k >= 1 && k <= 384) ? 1 : 0);
                check_eq("done", longint'(done), (k == 385) ? 1 : 0);
                check_eq("c_we", longint'(c_we), (k >= 6 && k <= 384 && k % 6 == 0) ? 1 : 0);
                n  = (k - 1) / 6;
                ph = (k - 1) % 6;
                ii = n / 8;
                jj = n % 8;
                if (k >= 1 && k <= 384 && ph < 4) begin
                    check_eq("a_addr1", longint'(a_addr1), ii*8 + 2*ph);
                    check_eq("a_addr2", longint'(a_addr2), ii*8 + 2*ph + 1);
                    check_eq("b_addr1", longint'(b_addr1), 2*ph*8 + jj);
                    check_eq("b_addr2", longint'(b_addr2), (2*ph+1)*8 + jj);
                end
                if (k >= 6 && k <= 384 && k % 6 == 0) begin
                    check_eq("c_addr", longint'(c_addr), k/6 - 1);
                    check_eq("c_data", longint'(c_data), ref_c((k/6 - 1) / 8, (k/6 - 1) % 8));
                end
            end
        end
        start = 1'b0;
        rst   = 1'b0;
        if (rst_cyc == 0) begin
            check_eq("write_count", wr_cnt, 64);
            check_eq("done_count", done_cnt, 1);
        end else begin
            check_eq("done_count_rst", done_cnt, 0);
        end
        if (chk_c) for (int x = 0; x < 64; x++) check_eq("c_mem", longint'(c_mem[x]), ref_c(x / 8, x % 8));
    endtask

    task automatic fill_random();
        for (int x = 0; x < 64; x++) begin
            a_mem[x] = 8'($urandom);
            b_mem[x] = 8'($urandom);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        for (int x = 0; x < 64; x++) begin
            a_mem[x] = '0;
            b_mem[x] = '0;
            c_mem[x] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", longint'(busy), 0);
        check_eq("rst_done", longint'(done), 0);
        check_eq("rst_we", longint'(c_we), 0);
        check_eq("rst_cdata", longint'(c_data), 0);
        check_eq("rst_caddr", longint'(c_addr), 0);
        check_eq("rst_addr", longint'({a_addr1, a_addr2, b_addr1, b_addr2}), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Identity A: C must reproduce B
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                a_mem[r*8+c] = (r == c) ? 8'sd1 : 8'sd0;
                b_mem[r*8+c] = 8'(r*8 + c - 32);
            end
        run_mult(-1, -1, 0, 1'b1);
        for (int x = 0; x < 64; x++) check_eq("ident_c", longint'(c_mem[x]), longint'(b_mem[x]));

        // Largest positive sum
        for (int x = 0; x < 64; x++) begin a_mem[x] = -8'sd128; b_mem[x] = -8'sd128; end
        run_mult(-1, -1, 0, 1'b1);
        check_eq("max_pos", longint'(c_mem[37]), 131072);

        // Largest negative sum
        for (int x = 0; x < 64; x++) begin a_mem[x] = 8'sd127; b_mem[x] = -8'sd128; end
        run_mult(-1, -1, 0, 1'b1);
        check_eq("max_neg", longint'(c_mem[0]), -130048);

        // Random data with start re-pulsed mid-run and during DONE
        fill_random();
        run_mult(50, 385, 0, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("idle_after_repulse", longint'(busy), 0);

        // Reset mid-operation, then a clean full run
        fill_random();
        run_mult(-1, -1, 100, 1'b0);
        fill_random();
        run_mult(-1, -1, 0, 1'b1);

        fill_random();
        run_mult(-1, -1, 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
